ram_prog_loader: RTL and testbench
==================================

Name: ram_prog_loader

Overview:
- Programming-side driver for the RAM address/data path. It consumes a byte stream and writes it into sequential RAM locations starting at 0.
- Drives the loader ("B") side of the RAM address mux and the programming data path. Its prog_mode output is the mux select: 1 means the loader owns the RAM.
- Generates the active-low RAM write strobe with setup and hold margins around each write.

Parameters:
ADDR_W, 4, RAM address width; depth is 2^ADDR_W locations.
DATA_W, 8, RAM word width.
WE_CYCLES, 2, cycles ram_we_n is held low per write; legal range 1..15.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a load session
abort  input  1  terminate session early
in_valid  input  1  in_data/in_last valid
in_data  input  DATA_W  byte to write
in_last  input  1  marks final byte of the session
in_ready  output  1  loader accepts a byte this cycle
prog_mode  output  1  RAM address mux select; 1 = loader address/data
prog_addr  output  ADDR_W  RAM address to the mux B input
prog_data  output  DATA_W  RAM write data
ram_we_n  output  1  active-low RAM write enable
busy  output  1  session in progress
done  output  1  one-cycle pulse at session end
count  output  ADDR_W+1  bytes written this session

Behaviour:
- One clock is used; reset is synchronous and active-low. On a clk edge with rst_n=0, all outputs take their reset values on that edge:
  - in_ready=0, prog_mode=0, prog_addr=0, prog_data=0, ram_we_n=1, busy=0, done=0, count=0, state=IDLE.
  - Reset during WRITE deasserts ram_we_n on that same edge.
- States: IDLE, LOAD, SETUP, WRITE, HOLD, DONE.
- IDLE:
  - Outputs at reset values, except count, which holds its last value.
  - in_valid is ignored.
  - start=1 -> LOAD; prog_addr=0, count=0, prog_mode=1, busy=1.
- LOAD:
  - in_ready=1, combinational from state.
  - A byte is accepted when in_valid&in_ready: latch prog_data=in_data and a last flag=in_last (or forced to 1 at address 2^ADDR_W-1), then -> SETUP.
  - abort=1 with no accept -> DONE. If abort and an accept occur in the same cycle, abort wins and the byte is dropped.
- SETUP: 1 cycle. ram_we_n=1; prog_addr/prog_data are stable so the address can settle through the mux. -> WRITE.
- WRITE:
  - ram_we_n=0 for exactly WE_CYCLES cycles, using an internal counter.
  - prog_addr and prog_data are held constant.
  - -> HOLD.
- HOLD: 1 cycle, ram_we_n=1, addr/data still held.
  - count increments.
  - If last flag or abort was seen since acceptance -> DONE.
  - Otherwise prog_addr increments -> LOAD.
- Abort outside LOAD is sticky until HOLD. An in-flight write always completes; it is never truncated.
- DONE: 1 cycle. done=1, prog_mode=0, busy=0, in_ready=0 -> IDLE. prog_addr holds the last written address until IDLE clears it.
- start is ignored in every state except IDLE.
- Address wrap: none. The write to address 2^ADDR_W-1 always ends the session, so count max = 2^ADDR_W.
- Latency:
  - Accept edge k; SETUP in cycle k+1.
  - ram_we_n low in cycles k+2..k+1+WE_CYCLES; HOLD at k+2+WE_CYCLES.
  - Next in_ready at k+3+WE_CYCLES.
  - Peak throughput: 1 byte per 3+WE_CYCLES cycles.
- prog_mode=1 exactly while the state is LOAD/SETUP/WRITE/HOLD. It is never 1 while ram_we_n transitions low from IDLE.

Test Plan:
- Full load (WE_CYCLES=2): start, then 16 bytes 0x00..0x0F with in_valid held high and in_last=0 throughout -> 16 write pulses, each 2 cycles low, at addresses 0..15 with data equal to the address. Session ends after address 15 without in_last; done pulses once; count=16; prog_mode falls with done; 5 cycles between accepts.
- Early end: bytes 0xA5, 0x5A, 0xFF with in_last on the third -> writes to addresses 0, 1, 2 only; count=3; done one cycle after the third HOLD.
- Abort in LOAD after 2 bytes -> no further ram_we_n pulse; DONE next cycle; count=2. Abort asserted during WRITE of byte 1 -> that write still completes its full 2 low cycles; count=1.
- Backpressure/ignore:
  - in_valid=1 while IDLE -> in_ready=0, no writes.
  - in_valid gaps of 0..7 cycles in LOAD -> addresses stay sequential, data is correct.
  - start pulsed mid-session -> no effect.
- Reset mid-write: rst_n=0 in the first low cycle of ram_we_n -> on that edge ram_we_n=1, prog_mode=0, busy=0, count=0. A following start begins again at address 0.
- Check SETUP and HOLD around every pulse: prog_addr/prog_data are stable for one cycle before ram_we_n falls and one cycle after it rises.

Source files
------------

// File: rtl/ram_prog_loader_if.sv
// Stream and RAM-programming signal bundle for ram_prog_loader.
// The slave modport is the loader itself; master is whoever feeds bytes
// and observes the RAM-side outputs.
interface ram_prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  // Session control
  logic              start;
  logic              abort;

  // Byte stream
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  // RAM programming path
  logic              prog_mode;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              ram_we_n;

  // Status
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  modport master (
    output start, abort, in_valid, in_data, in_last,
    input  in_ready, prog_mode, prog_addr, prog_data, ram_we_n,
           busy, done, count
  );

  modport slave (
    input  start, abort, in_valid, in_data, in_last,
    output in_ready, prog_mode, prog_addr, prog_data, ram_we_n,
           busy, done, count
  );

endinterface

// File: rtl/ram_prog_loader.sv
// RAM program loader: takes a byte stream and writes it to consecutive RAM
// locations from address 0, framing every write with one setup cycle, a
// WE_CYCLES-long active-low strobe and one hold cycle. prog_mode selects the
// loader side of the RAM address mux for the whole session.
module ram_prog_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WE_CYCLES = 2   // 1..15
) (
  input logic               clk,
  input logic               rst_n,
  ram_prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [3:0]        WE_LAST  = 4'(WE_CYCLES - 1);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [DATA_W-1:0] prog_data_q, prog_data_d;
  logic [ADDR_W:0]   count_q,     count_d;
  logic [3:0]        we_cnt_q,    we_cnt_d;
  logic              last_q,      last_d;
  logic              abort_q,     abort_d;

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of code order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      count_q     <= '0;
      we_cnt_q    <= '0;
      last_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      count_q     <= count_d;
      we_cnt_q    <= we_cnt_d;
      last_q      <= last_d;
      abort_q     <= abort_d;
    end
  end

  // Next-state and datapath update for the load session.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    count_d     = count_q;
    we_cnt_d    = we_cnt_q;
    last_d      = last_q;
    abort_d     = abort_q;

    unique case (state_q)
      S_IDLE: begin
        prog_addr_d = '0;
        prog_data_d = '0;
        if (bus.start) begin
          count_d = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Abort beats a simultaneous accept; the byte is dropped.
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (bus.in_valid) begin
          prog_data_d = bus.in_data;
          // The top address always closes the session: there is no wrap.
          last_d      = bus.in_last | (prog_addr_q == ADDR_MAX);
          abort_d     = 1'b0;
          state_d     = S_SETUP;
        end
      end

      S_SETUP: begin
        if (bus.abort) abort_d = 1'b1;
        we_cnt_d = WE_LAST;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        // Abort is only remembered here; the strobe always runs full length.
        if (bus.abort) abort_d = 1'b1;
        if (we_cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          we_cnt_d = we_cnt_q - 4'd1;
        end
      end

      S_HOLD: begin
        count_d = count_q + (ADDR_W+1)'(1);
        if (last_q || abort_q || bus.abort) begin
          state_d = S_DONE;
        end else begin
          prog_addr_d = prog_addr_q + ADDR_W'(1);
          state_d     = S_LOAD;
        end
      end

      S_DONE: begin
        // prog_addr stays visible during DONE and clears on entry to IDLE.
        prog_addr_d = '0;
        prog_data_d = '0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so they follow reset on the same edge.
  always_comb begin
    bus.in_ready  = (state_q == S_LOAD);
    bus.prog_mode = (state_q == S_LOAD)  || (state_q == S_SETUP) ||
                    (state_q == S_WRITE) || (state_q == S_HOLD);
    bus.busy      = bus.prog_mode;
    bus.ram_we_n  = (state_q != S_WRITE);
    bus.done      = (state_q == S_DONE);
    bus.prog_addr = prog_addr_q;
    bus.prog_data = prog_data_q;
    bus.count     = count_q;
  end

endmodule

// File: tb/tb_ram_prog_loader.sv
// Directed self-checking bench for ram_prog_loader (ADDR_W=4, DATA_W=8,
// WE_CYCLES=2). A negedge monitor logs every completed write pulse and flags
// address/data movement around the strobe; the main sequence checks state,
// logged writes and timing.
module tb_ram_prog_loader;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int WE_CYCLES = 2;
  localparam int CLK_P     = 10;

  logic clk = 1'b0;
  logic rst_n;

  ram_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_prog_loader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WE_CYCLES(WE_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #(CLK_P/2) clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Write-pulse monitor state
  logic              mon_en = 1'b1;
  logic              prev_we = 1'b1;
  logic              prev_mode = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0] pulse_addr = '0;
  logic [DATA_W-1:0] pulse_data = '0;
  int                low_len = 0;
  int                mon_err = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];
  longint            acc_t[$];

  // Log completed write pulses and flag strobe-framing violations.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (!mon_en) begin
      prev_we <= 1'b1;
      low_len <= 0;
    end else begin
      if (prev_we && !bus.ram_we_n) begin
        if (bus.prog_addr !== prev_addr || bus.prog_data !== prev_data ||
            prev_mode !== 1'b1 || bus.prog_mode !== 1'b1)
          mon_err <= mon_err + 1;
        low_len    <= 1;
        pulse_addr <= bus.prog_addr;
        pulse_data <= bus.prog_data;
      end else if (!prev_we && !bus.ram_we_n) begin
        if (bus.prog_addr !== pulse_addr || bus.prog_data !== pulse_data)
          mon_err <= mon_err + 1;
        low_len <= low_len + 1;
      end else if (!prev_we && bus.ram_we_n) begin
        if (low_len != WE_CYCLES || bus.prog_addr !== pulse_addr ||
            bus.prog_data !== pulse_data || bus.prog_mode !== 1'b1)
          mon_err <= mon_err + 1;
        log_addr.push_back(pulse_addr);
        log_data.push_back(pulse_data);
      end
      prev_we <= bus.ram_we_n;
    end
    prev_mode <= bus.prog_mode;
    prev_addr <= bus.prog_addr;
    prev_data <= bus.prog_data;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns on the negedge after accept.
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int t = 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) check("ready_timeout", 32'(bus.in_ready), 1);
    @(posedge clk);
    acc_t.push_back($time);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", 32'(bus.done), 1);
  endtask

  initial begin
    int base;
    int cyc;
    int dc;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_in_ready",  32'(bus.in_ready),  0);
    check("rst_prog_mode", 32'(bus.prog_mode), 0);
    check("rst_ram_we_n",  32'(bus.ram_we_n),  1);
    check("rst_busy",      32'(bus.busy),      0);
    check("rst_done",      32'(bus.done),      0);
    check("rst_count",     32'(bus.count),     0);
    check("rst_prog_addr", 32'(bus.prog_addr), 0);
    check("rst_prog_data", 32'(bus.prog_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid in IDLE is ignored
    base = log_addr.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (4) @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 0);
    check("idle_no_write", 32'(log_addr.size() - base), 0);
    bus.in_valid = 1'b0;

    // Full load: 16 bytes back to back, session ends at address 15
    base = log_addr.size();
    acc_t.delete();
    dc = done_cnt;
    pulse_start();
    check("start_busy",      32'(bus.busy),      1);
    check("start_prog_mode", 32'(bus.prog_mode), 1);
    check("start_in_ready",  32'(bus.in_ready),  1);
    check("start_count",     32'(bus.count),     0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 0);
    wait_done(cyc);
    check("full_done_lat",   32'(cyc),           4);
    check("full_mode_done",  32'(bus.prog_mode), 0);
    check("full_busy_done",  32'(bus.busy),      0);
    check("full_addr_done",  32'(bus.prog_addr), 15);
    check("full_count",      32'(bus.count),     16);
    @(negedge clk);
    check("full_done_once",  32'(done_cnt - dc), 1);
    check("full_idle_addr",  32'(bus.prog_addr), 0);
    check("full_idle_count", 32'(bus.count),     16);
    check("full_nwrites",    32'(log_addr.size() - base), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_addr%0d", i), 32'(log_addr[base+i]), i);
      check($sformatf("full_data%0d", i), 32'(log_data[base+i]), i);
    end
    for (int i = 1; i < 16; i++)
      check($sformatf("full_spacing%0d", i), 32'(acc_t[i] - acc_t[i-1]),
            5 * CLK_P);

    // Early end on in_last, with a stray start mid-session
    repeat (2) @(negedge clk);
    base = log_addr.size();
    pulse_start();
    send_byte(8'hA5, 1'b0, 0);
    pulse_start();
    send_byte(8'h5A, 1'b0, 0);
    send_byte(8'hFF, 1'b1, 0);
    wait_done(cyc);
    check("early_done_lat", 32'(cyc),       4);
    check("early_count",    32'(bus.count), 3);
    check("early_nwrites",  32'(log_addr.size() - base), 3);
    check("early_a0", 32'(log_addr[base+0]), 0);
    check("early_d0", 32'(log_data[base+0]), 32'hA5);
    check("early_a1", 32'(log_addr[base+1]), 1);
    check("early_d1", 32'(log_data[base+1]), 32'h5A);
    check("early_a2", 32'(log_addr[base+2]), 2);
    check("early_d2", 32'(log_data[base+2]), 32'hFF);

    // Abort in LOAD after two bytes, with a byte offered in the same cycle
    repeat (2) @(negedge clk);
    base = log_addr.size();
    pulse_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check("abl_done",  32'(bus.done),  1);
    check("abl_count", 32'(bus.count), 2);
    repeat (6) @(negedge clk);
    check("abl_nwrites", 32'(log_addr.size() - base), 2);

    // Abort during WRITE of the first byte: write completes, then DONE
    base = log_addr.size();
    pulse_start();
    send_byte(8'h77, 1'b0, 0);
    @(negedge clk);
    check("abw_we_low", 32'(bus.ram_we_n), 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abw_still_low", 32'(bus.ram_we_n), 0);
    wait_done(cyc);
    check("abw_done_lat", 32'(cyc),       2);
    check("abw_count",    32'(bus.count), 1);
    check("abw_nwrites",  32'(log_addr.size() - base), 1);
    check("abw_data",     32'(log_data[base]), 32'h77);

    // in_valid gaps of 0..7 cycles
    @(negedge clk);
    base = log_addr.size();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), (i == 7), i);
    wait_done(cyc);
    check("gap_count",   32'(bus.count), 8);
    check("gap_nwrites", 32'(log_addr.size() - base), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("gap_addr%0d", i), 32'(log_addr[base+i]), i);
      check($sformatf("gap_data%0d", i), 32'(log_data[base+i]), 32'h30 + i);
    end

    // Reset in the first low cycle of ram_we_n
    @(negedge clk);
    mon_en = 1'b0;
    pulse_start();
    send_byte(8'h99, 1'b0, 0);
    @(negedge clk);
    check("rstw_we_low", 32'(bus.ram_we_n), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstw_we_n",  32'(bus.ram_we_n),  1);
    check("rstw_mode",  32'(bus.prog_mode), 0);
    check("rstw_busy",  32'(bus.busy),      0);
    check("rstw_count", 32'(bus.count),     0);
    check("rstw_addr",  32'(bus.prog_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    base = log_addr.size();
    pulse_start();
    check("rstw_restart_addr", 32'(bus.prog_addr), 0);
    send_byte(8'h42, 1'b1, 0);
    wait_done(cyc);
    check("rstw_count2",   32'(bus.count), 1);
    check("rstw_nwrites",  32'(log_addr.size() - base), 1);
    check("rstw_addr2",    32'(log_addr[base]), 0);
    check("rstw_data2",    32'(log_data[base]), 32'h42);
    @(negedge clk);

    // Setup/hold framing and pulse width over the whole run
    check("strobe_framing", 32'(mon_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
